// File: rtl/flt_mul_normalizer.sv
// Normalise / round / saturate stage for the decomposable FP multiplier.
// Two-stage valid/ready pipeline serving one 32b, two 16b or four 8b lanes.
package pe_pkg;
  localparam int PRECISION_CONFIG_L = 2;
  localparam logic [PRECISION_CONFIG_L-1:0] PRECISION_CONFIG_32B = 2'd0;
  localparam logic [PRECISION_CONFIG_L-1:0] PRECISION_CONFIG_16B = 2'd1;
  localparam logic [PRECISION_CONFIG_L-1:0] PRECISION_CONFIG_8B  = 2'd2;
endpackage

module flt_mul_norm_lane #(
  parameter int M = 4,
  parameter int E = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         s1_en,
  input  logic         s2_en,
  input  logic         active,
  input  logic [M+1:0] m,
  input  logic [E:0]   e,
  output logic [M-1:0] frac_q,
  output logic [E-1:0] exp_q,
  output logic         zero_q,
  output logic         ovf_q,
  output logic         unf_q
);
  localparam logic signed [E+1:0] EXP_MAX = (E+2)'((2 ** (E-1)) - 1);
  localparam logic signed [E+1:0] EXP_MIN = (E+2)'(-(2 ** (E-1)));

  logic [M:0]            rnd_sum;
  logic [M-1:0]          norm_frac;
  logic signed [E+1:0]   norm_exp;
  logic                  norm_zero;
  logic [M-1:0]          s1_frac;
  logic signed [E+1:0]   s1_exp;
  logic                  s1_zero;
  logic                  s1_active;
  logic [M-1:0]          sat_frac;
  logic [E-1:0]          sat_exp;
  logic                  sat_zero;
  logic                  sat_ovf;
  logic                  sat_unf;

  // Guard-only round to nearest even; a carry out bumps the exponent once more.
  always_comb begin
    rnd_sum   = {1'b0, m[M:1]} + {{M{1'b0}}, m[0] & m[1]};
    norm_frac = m[M-1:0];
    norm_exp  = {e[E], e};
    norm_zero = (m[M+1:M] == 2'b00);
    if (m[M+1]) begin
      norm_frac = rnd_sum[M-1:0];
      norm_exp  = norm_exp + (E+2)'(rnd_sum[M] ? 2 : 1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_frac   <= '0;
      s1_exp    <= '0;
      s1_zero   <= 1'b0;
      s1_active <= 1'b0;
    end else if (s1_en) begin
      s1_frac   <= norm_frac;
      s1_exp    <= norm_exp;
      s1_zero   <= norm_zero;
      s1_active <= active;
    end
  end

  always_comb begin
    sat_frac = '0;
    sat_exp  = '0;
    sat_zero = 1'b0;
    sat_ovf  = 1'b0;
    sat_unf  = 1'b0;
    if (s1_active) begin
      if (s1_zero) begin
        sat_zero = 1'b1;
      end else if (s1_exp > EXP_MAX) begin
        sat_exp  = EXP_MAX[E-1:0];
        sat_frac = '1;
        sat_ovf  = 1'b1;
      end else if (s1_exp < EXP_MIN) begin
        sat_zero = 1'b1;
        sat_unf  = 1'b1;
      end else begin
        sat_exp  = s1_exp[E-1:0];
        sat_frac = s1_frac;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frac_q <= '0;
      exp_q  <= '0;
      zero_q <= 1'b0;
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
    end else if (s2_en) begin
      frac_q <= sat_frac;
      exp_q  <= sat_exp;
      zero_q <= sat_zero;
      ovf_q  <= sat_ovf;
      unf_q  <= sat_unf;
    end
  end
endmodule

module flt_mul_normalizer #(
  parameter int MANT_FULL_L        = 23,
  parameter int MANT_HALF_L        = 10,
  parameter int MANT_QUART_L       = 4,
  parameter int EXP_FULL_L         = 10,
  parameter int EXP_HALF_L         = 7,
  parameter int EXP_QUART_L        = 5,
  parameter int PRECISION_CONFIG_L = 2
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [PRECISION_CONFIG_L-1:0]       mode,
  input  logic [EXP_FULL_L:0]                 exp_full_in,
  input  logic [1:0][EXP_HALF_L:0]            exp_half_in,
  input  logic [3:0][EXP_QUART_L:0]           exp_quart_in,
  input  logic [MANT_FULL_L+1:0]              mant_full_in,
  input  logic [1:0][MANT_HALF_L+1:0]         mant_half_in,
  input  logic [3:0][MANT_QUART_L+1:0]        mant_quart_in,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [PRECISION_CONFIG_L-1:0]       mode_out,
  output logic [EXP_FULL_L-1:0]               exp_full_out,
  output logic [1:0][EXP_HALF_L-1:0]          exp_half_out,
  output logic [3:0][EXP_QUART_L-1:0]         exp_quart_out,
  output logic [MANT_FULL_L-1:0]              mant_full_out,
  output logic [1:0][MANT_HALF_L-1:0]         mant_half_out,
  output logic [3:0][MANT_QUART_L-1:0]        mant_quart_out,
  output logic [3:0]                          zero_out,
  output logic [3:0]                          ovf_out,
  output logic [3:0]                          unf_out,
  output logic [15:0]                         sat_cnt,
  input  logic                                sat_cnt_clr
);
  logic                          s1_valid;
  logic [PRECISION_CONFIG_L-1:0] s1_mode;
  logic                          s1_advance;
  logic                          s2_advance;
  logic                          act_full;
  logic                          act_half;
  logic                          act_quart;
  logic                          full_zero, full_ovf, full_unf;
  logic [1:0]                    half_zero, half_ovf, half_unf;
  logic [3:0]                    quart_zero, quart_ovf, quart_unf;
  logic [3:0]                    sat_bits;
  logic [2:0]                    sat_pop;
  logic [16:0]                   sat_sum;

  assign s2_advance = !out_valid || out_ready;
  assign s1_advance = !s1_valid || s2_advance;
  assign in_ready   = s1_advance;

  assign act_full  = (mode == pe_pkg::PRECISION_CONFIG_32B);
  assign act_half  = (mode == pe_pkg::PRECISION_CONFIG_16B);
  assign act_quart = (mode == pe_pkg::PRECISION_CONFIG_8B);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_mode   <= '0;
      out_valid <= 1'b0;
      mode_out  <= '0;
    end else begin
      if (s1_advance) begin
        s1_valid <= in_valid;
        s1_mode  <= mode;
      end
      if (s2_advance) begin
        out_valid <= s1_valid;
        mode_out  <= s1_mode;
      end
    end
  end

  flt_mul_norm_lane #(.M(MANT_FULL_L), .E(EXP_FULL_L)) u_full (
    .clk(clk), .rst_n(rst_n), .s1_en(s1_advance), .s2_en(s2_advance),
    .active(act_full), .m(mant_full_in), .e(exp_full_in),
    .frac_q(mant_full_out), .exp_q(exp_full_out),
    .zero_q(full_zero), .ovf_q(full_ovf), .unf_q(full_unf)
  );

  for (genvar gi = 0; gi < 2; gi++) begin : g_half
    flt_mul_norm_lane #(.M(MANT_HALF_L), .E(EXP_HALF_L)) u_half (
      .clk(clk), .rst_n(rst_n), .s1_en(s1_advance), .s2_en(s2_advance),
      .active(act_half), .m(mant_half_in[gi]), .e(exp_half_in[gi]),
      .frac_q(mant_half_out[gi]), .exp_q(exp_half_out[gi]),
      .zero_q(half_zero[gi]), .ovf_q(half_ovf[gi]), .unf_q(half_unf[gi])
    );
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_quart
    flt_mul_norm_lane #(.M(MANT_QUART_L), .E(EXP_QUART_L)) u_quart (
      .clk(clk), .rst_n(rst_n), .s1_en(s1_advance), .s2_en(s2_advance),
      .active(act_quart), .m(mant_quart_in[gi]), .e(exp_quart_in[gi]),
      .frac_q(mant_quart_out[gi]), .exp_q(exp_quart_out[gi]),
      .zero_q(quart_zero[gi]), .ovf_q(quart_ovf[gi]), .unf_q(quart_unf[gi])
    );
  end

  // Inactive lanes are forced to 0, so the per-mode flags can simply be OR-ed.
  assign zero_out = quart_zero | {2'b00, half_zero} | {3'b000, full_zero};
  assign ovf_out  = quart_ovf  | {2'b00, half_ovf}  | {3'b000, full_ovf};
  assign unf_out  = quart_unf  | {2'b00, half_unf}  | {3'b000, full_unf};

  always_comb begin
    sat_bits = ovf_out | unf_out;
    sat_pop  = '0;
    for (int i = 0; i < 4; i++) begin
      sat_pop = sat_pop + {2'b00, sat_bits[i]};
    end
    sat_sum = {1'b0, sat_cnt} + {14'd0, sat_pop};
  end

  always_ff @(posedge clk) begin
    if (!rst_n || sat_cnt_clr) begin
      sat_cnt <= '0;
    end else if (out_valid && out_ready) begin
      sat_cnt <= sat_sum[16] ? 16'hFFFF : sat_sum[15:0];
    end
  end
endmodule

// File: tb/tb_flt_mul_normalizer.sv
// Directed-vector bench for flt_mul_normalizer: arithmetic cases, backpressure, reset.
module tb_flt_mul_normalizer;
  localparam int MF = 23, MH = 10, MQ = 4, EF = 10, EH = 7, EQ = 5;

  logic clk = 1'b0;
  logic rst_n, in_valid, in_ready, out_valid, out_ready, sat_cnt_clr;
  logic [1:0] mode, mode_out;
  logic [EF:0] exp_full_in;
  logic [1:0][EH:0] exp_half_in;
  logic [3:0][EQ:0] exp_quart_in;
  logic [MF+1:0] mant_full_in;
  logic [1:0][MH+1:0] mant_half_in;
  logic [3:0][MQ+1:0] mant_quart_in;
  logic [EF-1:0] exp_full_out;
  logic [1:0][EH-1:0] exp_half_out;
  logic [3:0][EQ-1:0] exp_quart_out;
  logic [MF-1:0] mant_full_out;
  logic [1:0][MH-1:0] mant_half_out;
  logic [3:0][MQ-1:0] mant_quart_out;
  logic [3:0] zero_out, ovf_out, unf_out;
  logic [15:0] sat_cnt;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  flt_mul_normalizer dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .mode(mode),
    .exp_full_in(exp_full_in), .exp_half_in(exp_half_in), .exp_quart_in(exp_quart_in),
    .mant_full_in(mant_full_in), .mant_half_in(mant_half_in), .mant_quart_in(mant_quart_in),
    .out_valid(out_valid), .out_ready(out_ready), .mode_out(mode_out),
    .exp_full_out(exp_full_out), .exp_half_out(exp_half_out), .exp_quart_out(exp_quart_out),
    .mant_full_out(mant_full_out), .mant_half_out(mant_half_out), .mant_quart_out(mant_quart_out),
    .zero_out(zero_out), .ovf_out(ovf_out), .unf_out(unf_out),
    .sat_cnt(sat_cnt), .sat_cnt_clr(sat_cnt_clr)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic clear_inputs();
    exp_full_in = '0; exp_half_in = '0; exp_quart_in = '0;
    mant_full_in = '0; mant_half_in = '0; mant_quart_in = '0;
  endtask

  // One isolated transfer; returns on the negedge where the result should be presented.
  task automatic xfer_one(input string tag);
    @(negedge clk);
    in_valid = 1'b1;
    #1 check({tag, "_in_ready"}, in_ready, 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    check({tag, "_valid_c1"}, out_valid, 0);
    @(negedge clk);
    check({tag, "_valid_c2"}, out_valid, 1);
  endtask

  logic [3:0] exp_frac_q [6];
  logic [4:0] exp_exp_q [6];
  logic [8:0] held;
  logic was_stalled, saw_block, in_acc;
  int rcv, idx;

  task automatic load_stream(input int i);
    clear_inputs();
    if (i == 5) begin
      mant_quart_in[0] = 6'b10_0000;
      exp_quart_in[0]  = 6'd15;
    end else begin
      mant_quart_in[0] = {2'b01, 4'(i + 1)};
      exp_quart_in[0]  = 6'(i);
    end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; sat_cnt_clr = 1'b0;
    mode = pe_pkg::PRECISION_CONFIG_8B;
    clear_inputs();
    repeat (3) @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_sat_cnt", sat_cnt, 0);
    check("rst_flags", {zero_out, ovf_out, unf_out}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);

    // 8B basic normalise
    mant_quart_in[0] = 6'b10_1011; exp_quart_in[0] = 6'd3;
    mant_quart_in[1] = 6'b01_1010; exp_quart_in[1] = 6'b111110;
    xfer_one("t1");
    check("t1_mode", mode_out, pe_pkg::PRECISION_CONFIG_8B);
    check("t1_l0_frac", mant_quart_out[0], 4'b0110);
    check("t1_l0_exp", exp_quart_out[0], 5'd4);
    check("t1_l1_frac", mant_quart_out[1], 4'b1010);
    check("t1_l1_exp", exp_quart_out[1], 5'b11110);
    check("t1_zero", zero_out, 4'b1100);
    check("t1_ovf_unf", {ovf_out, unf_out}, 0);

    // 8B rounding carry and tie-to-even
    clear_inputs();
    mant_quart_in[0] = 6'b11_1111;
    mant_quart_in[2] = 6'b10_0001;
    xfer_one("t2");
    check("t2_l0_frac", mant_quart_out[0], 4'b0000);
    check("t2_l0_exp", exp_quart_out[0], 5'd2);
    check("t2_l2_frac", mant_quart_out[2], 4'b0000);
    check("t2_l2_exp", exp_quart_out[2], 5'd1);
    check("t2_zero", zero_out, 4'b1010);

    // 8B overflow / underflow
    clear_inputs();
    mant_quart_in[0] = 6'b10_0000; exp_quart_in[0] = 6'd15;
    mant_quart_in[1] = 6'b01_0000; exp_quart_in[1] = 6'b101111;
    xfer_one("t3");
    check("t3_l0_exp", exp_quart_out[0], 5'd15);
    check("t3_l0_frac", mant_quart_out[0], 4'hF);
    check("t3_l1", {exp_quart_out[1], mant_quart_out[1]}, 0);
    check("t3_ovf", ovf_out, 4'b0001);
    check("t3_unf", unf_out, 4'b0010);
    check("t3_zero", zero_out, 4'b1110);
    @(negedge clk);
    check("t3_sat_cnt", sat_cnt, 2);

    // 32B overflow
    clear_inputs();
    mode = pe_pkg::PRECISION_CONFIG_32B;
    mant_full_in = 25'h1000000; exp_full_in = 11'd511;
    xfer_one("t4");
    check("t4_mode", mode_out, pe_pkg::PRECISION_CONFIG_32B);
    check("t4_exp", exp_full_out, 10'd511);
    check("t4_frac", mant_full_out, 23'h7FFFFF);
    check("t4_ovf", ovf_out, 4'b0001);
    check("t4_zero_unf", {zero_out, unf_out}, 0);
    check("t4_other_lanes", {exp_half_out, exp_quart_out, mant_half_out[0]}, 0);
    check("t4_other_mant", {mant_half_out[1], mant_quart_out}, 0);

    // 16B rounding and exponent exactly at MIN
    clear_inputs();
    mode = pe_pkg::PRECISION_CONFIG_16B;
    mant_half_in[0] = 12'b10_0000000011; exp_half_in[0] = 8'd5;
    mant_half_in[1] = 12'b01_1111111111; exp_half_in[1] = 8'b11000000;
    xfer_one("t5");
    check("t5_h0_frac", mant_half_out[0], 10'd2);
    check("t5_h0_exp", exp_half_out[0], 7'd6);
    check("t5_h1_frac", mant_half_out[1], 10'h3FF);
    check("t5_h1_exp", exp_half_out[1], 7'b1000000);
    check("t5_flags", {zero_out, ovf_out, unf_out}, 0);
    check("t5_sat_cnt", sat_cnt, 3);

    // unknown mode: transaction flows, everything zero
    clear_inputs();
    mode = 2'd3;
    mant_quart_in[0] = 6'b10_1011; mant_full_in = 25'h1000000;
    xfer_one("t6");
    check("t6_mode", mode_out, 2'd3);
    check("t6_data", {exp_quart_out, mant_quart_out, exp_full_out}, 0);
    check("t6_flags", {zero_out, ovf_out, unf_out}, 0);

    // backpressure stream
    for (int i = 0; i < 6; i++) begin
      exp_frac_q[i] = (i == 5) ? 4'hF : 4'(i + 1);
      exp_exp_q[i]  = (i == 5) ? 5'd15 : 5'(i);
    end
    mode = pe_pkg::PRECISION_CONFIG_8B;
    @(negedge clk);
    @(posedge clk);
    #1;
    idx = 0; rcv = 0; was_stalled = 0; saw_block = 0; held = '0;
    load_stream(0);
    in_valid = 1'b1;
    for (int cyc = 0; cyc < 60 && rcv < 6; cyc++) begin
      @(negedge clk);
      out_ready   = !(cyc >= 3 && cyc <= 7);
      sat_cnt_clr = (cyc == 5);
      #1;
      if (cyc == 6) check("bp_sat_clr", sat_cnt, 0);
      if (out_valid && was_stalled)
        check("bp_hold_stable", {exp_quart_out[0], mant_quart_out[0]}, held);
      was_stalled = out_valid && !out_ready;
      held = {exp_quart_out[0], mant_quart_out[0]};
      if (out_valid && out_ready) begin
        check($sformatf("bp_rx%0d", rcv), {exp_quart_out[0], mant_quart_out[0]},
              {exp_exp_q[rcv], exp_frac_q[rcv]});
        rcv++;
      end
      if (in_valid && !in_ready) saw_block = 1'b1;
      in_acc = in_valid && in_ready;
      @(posedge clk);
      #1;
      if (in_acc) begin
        idx++;
        if (idx < 6) load_stream(idx);
        else in_valid = 1'b0;
      end
    end
    in_valid = 1'b0; out_ready = 1'b1; sat_cnt_clr = 1'b0;
    check("bp_rx_count", rcv, 6);
    check("bp_in_ready_dropped", saw_block, 1);
    @(negedge clk);
    check("bp_no_dup", out_valid, 0);
    check("bp_sat_cnt", sat_cnt, 1);

    // reset with two transactions in flight
    clear_inputs();
    mant_quart_in[0] = 6'b10_0000; exp_quart_in[0] = 6'd15;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    mant_quart_in[0] = 6'b01_0011; exp_quart_in[0] = 6'd2;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("rst2_out_valid", out_valid, 0);
    check("rst2_data", {exp_quart_out, mant_quart_out, mode_out}, 0);
    check("rst2_flags", {zero_out, ovf_out, unf_out}, 0);
    check("rst2_sat_cnt", sat_cnt, 0);
    check("rst2_in_ready", in_ready, 1);
    saw_block = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (out_valid) saw_block = 1'b1;
    end
    check("rst2_no_valid_after", saw_block, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
